// File: rtl/axi4_wlast_regen.sv
// ---------------------------------------------------------------------------
// axi4_wlast_regen
//
// Write-channel ordering stage that sits directly upstream of an AXI4
// width/data converter. Accepted AW burst lengths are queued. W beats are
// released only after their burst's AW has been accepted. WLAST is
// regenerated from a beat counter compared against the queued length, so the
// downstream converter always sees a correctly terminated burst. A
// disagreement between the upstream WLAST and the regenerated one is flagged
// on err_last. The upstream value is never forwarded.
//
// Handshake semantics: a transfer happens in any cycle where valid and ready
// are both high on the same channel. Valid never depends on ready on the
// same side. Both channels are pure combinational pass-throughs gated by the
// length FIFO state: AW is held while the FIFO is full, and W is held while
// it is empty.
//
// Parameters:
//   LSIZE  width of awlen (beats per burst = len + 1)
//   DSIZE  W data width (pass-through)
//   DEPTH  outstanding AW bursts whose data is not yet complete (power of 2, >= 2)
//
// Ports:
//   clock, rst_n                        clock and asynchronous active-low reset
//   in_aw_len/valid/ready               upstream AW channel
//   out_aw_len/valid/ready              downstream AW channel
//   in_w_data/last/valid/ready          upstream W channel (last is checked only)
//   out_w_data/last/valid/ready         downstream W channel (last regenerated)
//   err_last                            one-cycle pulse after a WLAST mismatch
//   err_cnt                             saturating mismatch count (optional)
//   pending                             length FIFO occupancy (debug/state view)
//
// Build option: define AXI4_WLAST_REGEN_ERR_CNT_EN to build the 16-bit
// saturating mismatch counter. Without it, err_cnt is tied to zero.
// ---------------------------------------------------------------------------
module axi4_wlast_regen #(
  parameter int LSIZE = 8,
  parameter int DSIZE = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [LSIZE-1:0]         in_aw_len,
  input  logic                     in_aw_valid,
  output logic                     in_aw_ready,
  output logic [LSIZE-1:0]         out_aw_len,
  output logic                     out_aw_valid,
  input  logic                     out_aw_ready,
  input  logic [DSIZE-1:0]         in_w_data,
  input  logic                     in_w_last,
  input  logic                     in_w_valid,
  output logic                     in_w_ready,
  output logic [DSIZE-1:0]         out_w_data,
  output logic                     out_w_last,
  output logic                     out_w_valid,
  input  logic                     out_w_ready,
  output logic                     err_last,
  output logic [15:0]              err_cnt,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW_W = $clog2(DEPTH);
  localparam int PW   = AW_W + 1;

  logic [LSIZE-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LSIZE-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_last_q, err_last_d;

  logic             full;
  logic             empty;
  logic             aw_push;
  logic             w_fire;
  logic [LSIZE-1:0] head_len;

  // Full/empty come from registered pointers only, so a pop in the same cycle
  // does not release a stalled AW until the next cycle.
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW_W-1:0] == rd_ptr_q[AW_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Handshake outputs are gated by rst_n so nothing moves while in reset.
  assign out_aw_valid = rst_n & in_aw_valid & ~full;
  assign in_aw_ready  = rst_n & out_aw_ready & ~full;
  assign out_aw_len   = in_aw_len;

  assign out_w_valid  = rst_n & in_w_valid & ~empty;
  assign in_w_ready   = rst_n & out_w_ready & ~empty;
  assign out_w_data   = in_w_data;

  assign head_len   = mem_q[rd_ptr_q[AW_W-1:0]];
  assign out_w_last = (beat_cnt_q == head_len);

  assign aw_push = out_aw_valid & out_aw_ready;
  assign w_fire  = out_w_valid & out_w_ready;

  assign pending  = wr_ptr_q - rd_ptr_q;
  assign err_last = err_last_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_last_d = 1'b0;
    if (aw_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (w_fire) begin
      // The burst boundary is implied by beat_cnt reaching head_len. Clearing
      // there means an all-ones length never wraps the counter mid-burst.
      if (out_w_last) begin
        beat_cnt_d = '0;
        rd_ptr_d   = rd_ptr_q + PW'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + LSIZE'(1);
      end
      err_last_d = (in_w_last != out_w_last);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
      err_last_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_last_q <= err_last_d;
    end
  end

  // Length storage needs no reset. Entries are only read between a push and
  // its pop.
  always_ff @(posedge clock) begin
    if (aw_push) begin
      mem_q[wr_ptr_q[AW_W-1:0]] <= in_aw_len;
    end
  end

`ifdef AXI4_WLAST_REGEN_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_last_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_axi4_wlast_regen.sv
// ---------------------------------------------------------------------------
// Directed bench for axi4_wlast_regen (LSIZE=8, DSIZE=32, DEPTH=4).
// Inputs change 1 time unit after a rising edge. Combinational outputs are
// sampled 1 time unit after that. Registered outputs are sampled after the
// next rising edge.
// ---------------------------------------------------------------------------
module tb_axi4_wlast_regen;

  localparam int LSIZE = 8;
  localparam int DSIZE = 32;
  localparam int DEPTH = 4;

`ifdef AXI4_WLAST_REGEN_ERR_CNT_EN
  localparam logic [15:0] ERR_ONE = 16'd1;
`else
  localparam logic [15:0] ERR_ONE = 16'd0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic [LSIZE-1:0] in_aw_len;
  logic             in_aw_valid;
  logic             in_aw_ready;
  logic [LSIZE-1:0] out_aw_len;
  logic             out_aw_valid;
  logic             out_aw_ready;
  logic [DSIZE-1:0] in_w_data;
  logic             in_w_last;
  logic             in_w_valid;
  logic             in_w_ready;
  logic [DSIZE-1:0] out_w_data;
  logic             out_w_last;
  logic             out_w_valid;
  logic             out_w_ready;
  logic             err_last;
  logic [15:0]      err_cnt;
  logic [$clog2(DEPTH):0] pending;

  axi4_wlast_regen #(.LSIZE(LSIZE), .DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .in_aw_len    (in_aw_len),
    .in_aw_valid  (in_aw_valid),
    .in_aw_ready  (in_aw_ready),
    .out_aw_len   (out_aw_len),
    .out_aw_valid (out_aw_valid),
    .out_aw_ready (out_aw_ready),
    .in_w_data    (in_w_data),
    .in_w_last    (in_w_last),
    .in_w_valid   (in_w_valid),
    .in_w_ready   (in_w_ready),
    .out_w_data   (out_w_data),
    .out_w_last   (out_w_last),
    .out_w_valid  (out_w_valid),
    .out_w_ready  (out_w_ready),
    .err_last     (err_last),
    .err_cnt      (err_cnt),
    .pending      (pending)
  );

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // advance one clock: returns 1 unit after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    in_aw_len    = '0;
    in_aw_valid  = 1'b0;
    out_aw_ready = 1'b1;
    in_w_data    = '0;
    in_w_last    = 1'b0;
    in_w_valid   = 1'b0;
    out_w_ready  = 1'b1;

    // ---------------- reset ----------------
    step();
    in_aw_valid = 1'b1;
    in_w_valid  = 1'b1;
    #1;
    chk("rst_out_aw_valid", 32'(out_aw_valid), 32'd0);
    chk("rst_in_aw_ready",  32'(in_aw_ready),  32'd0);
    chk("rst_out_w_valid",  32'(out_w_valid),  32'd0);
    chk("rst_in_w_ready",   32'(in_w_ready),   32'd0);
    chk("rst_pending",      32'(pending),      32'd0);
    chk("rst_err_last",     32'(err_last),     32'd0);
    chk("rst_err_cnt",      32'(err_cnt),      32'd0);
    in_aw_valid = 1'b0;
    in_w_valid  = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // ---------------- T1: len=3, 4 beats ----------------
    in_aw_valid = 1'b1;
    in_aw_len   = 8'd3;
    #1;
    chk("t1_aw_ready",   32'(in_aw_ready),  32'd1);
    chk("t1_aw_valid",   32'(out_aw_valid), 32'd1);
    chk("t1_aw_len",     32'(out_aw_len),   32'd3);
    chk("t1_w_blocked",  32'(in_w_ready),   32'd0);
    step();
    in_aw_valid = 1'b0;
    chk("t1_pending1", 32'(pending), 32'd1);
    for (int i = 0; i < 4; i++) begin
      in_w_valid = 1'b1;
      in_w_data  = 32'hA0 + 32'(i);
      in_w_last  = (i == 3);
      #1;
      chk("t1_w_ready", 32'(in_w_ready),  32'd1);
      chk("t1_w_last",  32'(out_w_last),  32'(i == 3));
      chk("t1_w_data",  out_w_data,       32'hA0 + 32'(i));
      step();
      chk("t1_err_last", 32'(err_last), 32'd0);
    end
    in_w_valid = 1'b0;
    in_w_last  = 1'b0;
    chk("t1_pending0", 32'(pending), 32'd0);

    // ---------------- T2: W before AW (len=0) ----------------
    in_w_valid = 1'b1;
    in_w_last  = 1'b1;
    in_w_data  = 32'h5555;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_w_stall",  32'(in_w_ready),  32'd0);
      chk("t2_w_vstall", 32'(out_w_valid), 32'd0);
      step();
    end
    in_aw_valid = 1'b1;
    in_aw_len   = 8'd0;
    #1;
    chk("t2_w_with_aw", 32'(in_w_ready), 32'd0);
    step();
    in_aw_valid = 1'b0;
    #1;
    chk("t2_w_ready", 32'(in_w_ready), 32'd1);
    chk("t2_w_last",  32'(out_w_last), 32'd1);
    step();
    in_w_valid = 1'b0;
    chk("t2_pending", 32'(pending),  32'd0);
    chk("t2_err",     32'(err_last), 32'd0);

    // ---------------- T3: fill to DEPTH, 5th stalls ----------------
    out_w_ready = 1'b0;
    begin
      logic [LSIZE-1:0] lens [5];
      lens[0] = 8'd1; lens[1] = 8'd0; lens[2] = 8'd0; lens[3] = 8'd0; lens[4] = 8'd4;
      for (int k = 0; k < 4; k++) begin
        in_aw_valid = 1'b1;
        in_aw_len   = lens[k];
        #1;
        chk("t3_aw_ready", 32'(in_aw_ready), 32'd1);
        step();
      end
      in_aw_len = lens[4];
      #1;
      chk("t3_full_pending", 32'(pending),      32'd4);
      chk("t3_full_ready",   32'(in_aw_ready),  32'd0);
      chk("t3_full_valid",   32'(out_aw_valid), 32'd0);
      step();
      // complete the len=1 burst at the head
      out_w_ready = 1'b1;
      in_w_valid  = 1'b1;
      in_w_last   = 1'b0;
      #1;
      chk("t3_b0_last",  32'(out_w_last),  32'd0);
      chk("t3_b0_awrdy", 32'(in_aw_ready), 32'd0);
      step();
      in_w_last = 1'b1;
      #1;
      chk("t3_b1_last",  32'(out_w_last),  32'd1);
      chk("t3_pop_awrdy", 32'(in_aw_ready), 32'd0);
      step();
      in_w_valid = 1'b0;
      #1;
      chk("t3_after_pop_pending", 32'(pending),     32'd3);
      chk("t3_after_pop_awrdy",   32'(in_aw_ready), 32'd1);
      step();
      in_aw_valid = 1'b0;
      chk("t3_refill_pending", 32'(pending), 32'd4);
      // drain three single-beat bursts then the len=4 burst
      in_w_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        in_w_last = (i < 3) || (i == 7);
        #1;
        chk("t3_drain_last", 32'(out_w_last), 32'((i < 3) || (i == 7)));
        step();
      end
      in_w_valid = 1'b0;
      in_w_last  = 1'b0;
      chk("t3_drain_pending", 32'(pending), 32'd0);
      chk("t3_drain_err",     32'(err_last), 32'd0);
    end

    // ---------------- T4: early upstream WLAST ----------------
    in_aw_valid = 1'b1;
    in_aw_len   = 8'd1;
    step();
    in_aw_valid = 1'b0;
    in_w_valid  = 1'b1;
    in_w_last   = 1'b1;
    #1;
    chk("t4_b0_last", 32'(out_w_last), 32'd0);
    step();
    chk("t4_err_pulse", 32'(err_last), 32'd1);
    #1;
    chk("t4_b1_last", 32'(out_w_last), 32'd1);
    step();
    in_w_valid = 1'b0;
    in_w_last  = 1'b0;
    chk("t4_err_clear", 32'(err_last), 32'd0);
    chk("t4_err_cnt",   32'(err_cnt),  32'(ERR_ONE));
    step();
    chk("t4_err_cnt_hold", 32'(err_cnt), 32'(ERR_ONE));

    // ---------------- T5: len=255 then len=0, no bubble ----------------
    in_aw_valid = 1'b1;
    in_aw_len   = 8'd255;
    step();
    in_aw_len   = 8'd0;
    step();
    in_aw_valid = 1'b0;
    chk("t5_pending2", 32'(pending), 32'd2);
    in_w_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_w_last = (i >= 255);
      in_w_data = 32'(i);
      #1;
      chk("t5_w_ready", 32'(in_w_ready), 32'd1);
      chk("t5_w_last",  32'(out_w_last), 32'(i >= 255));
      step();
    end
    in_w_valid = 1'b0;
    in_w_last  = 1'b0;
    chk("t5_pending0", 32'(pending), 32'd0);
    chk("t5_err",      32'(err_last), 32'd0);

    // ---------------- T6: async reset mid-burst ----------------
    in_aw_valid = 1'b1;
    in_aw_len   = 8'd7;
    step();
    in_aw_valid = 1'b0;
    in_w_valid  = 1'b1;
    in_w_last   = 1'b0;
    step();
    step();
    chk("t6_pre_pending", 32'(pending), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pending", 32'(pending),     32'd0);
    chk("t6_rst_w_valid", 32'(out_w_valid), 32'd0);
    in_w_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    in_aw_valid = 1'b1;
    in_aw_len   = 8'd1;
    step();
    in_aw_valid = 1'b0;
    in_w_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_w_last = (i == 1);
      #1;
      chk("t6_w_ready", 32'(in_w_ready), 32'd1);
      chk("t6_w_last",  32'(out_w_last), 32'(i == 1));
      step();
      chk("t6_err", 32'(err_last), 32'd0);
    end
    in_w_valid = 1'b0;
    chk("t6_pending0", 32'(pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/axi4_wlast_regen.md
# axi4_wlast_regen

Write-channel ordering stage placed directly upstream of the AXI4 width/data converter. It queues accepted AW burst lengths and lets W beats through only once their burst's address has been accepted. It counts beats against the queued length and regenerates WLAST so the downstream converter always sees a correctly terminated burst. A mismatch between the upstream WLAST and the computed one is flagged and never propagated.

## Interface
Parameters:
- LSIZE, 8, width of awlen (beats per burst = len+1)
- DSIZE, 32, W data width (pass-through)
- DEPTH, 4, max outstanding AW bursts whose data is not yet complete; power of 2, ≥2

Ports:
- clock  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- in_aw_len  in  LSIZE  upstream burst length
- in_aw_valid  in  1  upstream AW valid
- in_aw_ready  out  1  upstream AW ready
- out_aw_len  out  LSIZE  = in_aw_len
- out_aw_valid  out  1  downstream AW valid
- out_aw_ready  in  1  downstream AW ready
- in_w_data  in  DSIZE  upstream W data
- in_w_last  in  1  upstream WLAST, checked only
- in_w_valid  in  1  upstream W valid
- in_w_ready  out  1  upstream W ready
- out_w_data  out  DSIZE  = in_w_data
- out_w_last  out  1  regenerated WLAST
- out_w_valid  out  1  downstream W valid
- out_w_ready  in  1  downstream W ready
- err_last  out  1  one-cycle pulse on a WLAST mismatch
- err_cnt  out  16  mismatch count (see Configuration)
- pending  out  log2(DEPTH)+1  length FIFO occupancy

## Operation
- Length FIFO: DEPTH entries × LSIZE bits; rd/wr pointers of log2(DEPTH)+1 bits; full when MSBs differ and LSBs are equal; empty when pointers are equal.
- AW path, combinational: out_aw_valid = in_aw_valid & !full; in_aw_ready = out_aw_ready & !full. An AW handshake (out_aw_valid & out_aw_ready) pushes in_aw_len.
- W path, combinational: out_w_valid = in_w_valid & !empty; in_w_ready = out_w_ready & !empty. Data passes through unchanged.
- beat_cnt (LSIZE bits) counts beats of the burst at the FIFO head. out_w_last = (beat_cnt == head_len).
- On a W handshake:
  - if out_w_last is high, beat_cnt clears to 0 and the FIFO pops;
  - otherwise beat_cnt increments.
- Mismatch: on a W handshake with in_w_last ≠ out_w_last, err_last pulses high for the next cycle. The beat is still forwarded with the regenerated last.
- No state machine beyond the FIFO and counter. The burst boundary is entirely implied by beat_cnt and head_len.

## Timing
- Reset values: FIFO pointers 0 (empty), beat_cnt 0, err_last 0, err_cnt 0, pending 0.
- While rst_n is low, out_aw_valid, out_w_valid, in_aw_ready and in_w_ready are forced to 0.
- AW→AW and W→W have zero latency (combinational). No W bubble occurs between bursts when the FIFO holds the next length.
- A push is registered: a length pushed in cycle N enables W no earlier than cycle N+1. W arriving before or with its AW stalls.
- Full: AW is stalled even if a pop happens in the same cycle (the full check is registered). Push and pop in the same non-full cycle leave occupancy unchanged.
- Single-beat burst (len 0): out_w_last is high on its first beat, and the entry pops immediately.
- len = 2^LSIZE−1: beat_cnt reaches all-ones and never wraps mid-burst.
- Pointers wrap modulo 2·DEPTH.
- Asynchronous reset mid-burst discards queued lengths and the partial beat count. The next burst starts clean.

## Configuration
- Macro AXI4_WLAST_REGEN_ERR_CNT_EN.
- Defined: err_cnt is a 16-bit counter that increments on each err_last pulse and saturates at 16'hFFFF.
- Undefined: err_cnt is tied to 0 and no counter is built. err_last behaves identically in both builds.

## Test plan
- Reset, then AW len=3 followed by 4 W beats, all with correct in_w_last → out_w_last only on beat 4, pending 1→0, err_last never asserted.
- W valid held for 5 cycles before the AW (len=0) handshake → in_w_ready=0 until the cycle after the AW handshake, then 1 beat with out_w_last=1.
- DEPTH=4: 5 AWs back-to-back with out_w_ready=0 → the 5th is stalled (in_aw_ready=0, pending=4). After one burst completes, the 5th is accepted the next cycle.
- AW len=1 with upstream in_w_last asserted on beat 1 → forwarded beats have last 0,1; err_last pulses once; err_cnt=1 (macro defined) or 0 (undefined).
- Burst len=255 (LSIZE=8), then len=0 back-to-back → last on beat 256 and on the following beat, with no idle cycle between them.
- rst_n pulsed low after beat 2 of a len=7 burst → pending=0 and out_w_valid=0. A new AW len=1 followed by 2 beats terminates correctly.
